address_generator_2d: RTL and testbench

Parametrised successor to the single-counter enable-driven address generator. Produces a raster-scan address sequence over a rectangular window of a linear memory: run-time base, column count, row count and row stride. Supports single-shot and continuous modes, with a valid/enable step handshake and done/abort control. Sits between frame-buffer BRAMs and the window and convolution datapaths.

---
 rtl/address_generator_2d.sv | 164 ++++++++++++++++
 tb/tb_address_generator_2d.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/address_generator_2d.sv
// address_generator_2d
//   Raster-scan address generator over a rectangular window of a linear
//   memory. A start pulse latches base/cols/rows/stride (and the continuous
//   flag); each enable-accepted address advances the scan along the row and
//   then jumps to the next row start (row_base + stride). Single-shot scans end
//   with a one-cycle done pulse; continuous scans wrap to base with no gap.
//
// Ports
//   clock, reset          rising-edge clock, async active-high reset
//   start, stop           begin a scan (IDLE only) / abort to IDLE (priority)
//   enable                consumer accepts the current address
//   continuous            latched at start: wrap forever instead of finishing
//   cfg_base/cols/rows/stride  window description, latched at start
//   address, valid        current address and its qualifier
//   last_col, last_row    current element ends a row / lies in the last row
//   busy, done            not IDLE / single-shot completion pulse
module address_generator_2d #(
    parameter int             AW         = 16,
    parameter int             DW         = 10,
    parameter logic [AW-1:0]  RESET_ADDR = '0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic          enable,
    input  logic          continuous,
    input  logic [AW-1:0] cfg_base,
    input  logic [DW-1:0] cfg_cols,
    input  logic [DW-1:0] cfg_rows,
    input  logic [AW-1:0] cfg_stride,
    output logic [AW-1:0] address,
    output logic          valid,
    output logic          last_col,
    output logic          last_row,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [DW-1:0] ONE = DW'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] stride_q, stride_d;
    logic [DW-1:0] col_q, col_d;
    logic [DW-1:0] row_q, row_d;
    logic [DW-1:0] cols_q, cols_d;
    logic [DW-1:0] rows_q, rows_d;
    logic          cont_q, cont_d;

    logic col_end, row_end;

    // cols_q/rows_q are never zero while in RUN, so the -1 cannot underflow
    // where the decode matters; outside RUN the results are masked by valid.
    assign col_end = (col_q == cols_q - ONE);
    assign row_end = (row_q == rows_q - ONE);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        row_base_d = row_base_q;
        base_d     = base_q;
        stride_d   = stride_q;
        col_d      = col_q;
        row_d      = row_q;
        cols_d     = cols_q;
        rows_d     = rows_q;
        cont_d     = cont_q;

        case (state_q)
            S_IDLE: begin
                addr_d = RESET_ADDR;
                // Zero-sized windows are rejected outright.
                if (start && (cfg_cols != '0) && (cfg_rows != '0)) begin
                    state_d    = S_RUN;
                    base_d     = cfg_base;
                    stride_d   = cfg_stride;
                    cols_d     = cfg_cols;
                    rows_d     = cfg_rows;
                    cont_d     = continuous;
                    addr_d     = cfg_base;
                    row_base_d = cfg_base;
                    col_d      = '0;
                    row_d      = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                    addr_d  = RESET_ADDR;
                    col_d   = '0;
                    row_d   = '0;
                end else if (enable) begin
                    if (!col_end) begin
                        col_d  = col_q + ONE;
                        addr_d = addr_q + AW'(1);
                    end else if (!row_end) begin
                        col_d      = '0;
                        row_d      = row_q + ONE;
                        row_base_d = row_base_q + stride_q;
                        addr_d     = row_base_q + stride_q;
                    end else if (cont_q) begin
                        col_d      = '0;
                        row_d      = '0;
                        row_base_d = base_q;
                        addr_d     = base_q;
                    end else begin
                        state_d = S_DONE;
                        addr_d  = RESET_ADDR;
                        col_d   = '0;
                        row_d   = '0;
                    end
                end
            end
            S_DONE: begin
                // Stop here also lands in IDLE; done is already showing.
                state_d = S_IDLE;
                addr_d  = RESET_ADDR;
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = RESET_ADDR;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= RESET_ADDR;
            row_base_q <= '0;
            base_q     <= '0;
            stride_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            cols_q     <= '0;
            rows_q     <= '0;
            cont_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            row_base_q <= row_base_d;
            base_q     <= base_d;
            stride_q   <= stride_d;
            col_q      <= col_d;
            row_q      <= row_d;
            cols_q     <= cols_d;
            rows_q     <= rows_d;
            cont_q     <= cont_d;
        end
    end

    assign address  = addr_q;
    assign valid    = (state_q == S_RUN);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign last_col = valid & col_end;
    assign last_row = valid & row_end;

endmodule

// File: tb/tb_address_generator_2d.sv
// Scoreboard bench: stimulus pushes expected accepted addresses, a negedge
// monitor pops and compares every valid&enable beat and counts done pulses.
module tb_address_generator_2d;

    logic        clock = 1'b0;
    logic        reset, start, stop, enable, continuous;
    logic [15:0] cfg_base, cfg_stride;
    logic [9:0]  cfg_cols, cfg_rows;
    logic [15:0] address;
    logic        valid, last_col, last_row, busy, done;

    address_generator_2d dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .enable(enable), .continuous(continuous),
        .cfg_base(cfg_base), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
        .cfg_stride(cfg_stride),
        .address(address), .valid(valid), .last_col(last_col),
        .last_row(last_row), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] a;
        logic        lc;
        logic        lr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   done_seen = 0;
    int   exp_done  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic lc, input logic lr);
        exp_t e;
        e.a = a; e.lc = lc; e.lr = lr;
        sb.push_back(e);
    endtask

    // Monitor: compares each accepted beat against the scoreboard head.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (done) done_seen++;
                if (valid && enable) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got addr %0h with empty scoreboard", address);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("beat", {address, last_col, last_row}, {e.a, e.lc, e.lr});
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [15:0] b, input logic [9:0] c, input logic [9:0] r,
                            input logic [15:0] s, input logic cont);
        cfg_base = b; cfg_cols = c; cfg_rows = r; cfg_stride = s; continuous = cont;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic push_a();
        push(16'h0100, 0, 0); push(16'h0101, 0, 0); push(16'h0102, 1, 0);
        push(16'h0140, 0, 1); push(16'h0141, 0, 1); push(16'h0142, 1, 1);
    endtask

    initial begin
        reset = 1'b1; start = 0; stop = 0; enable = 0; continuous = 0;
        cfg_base = 0; cfg_cols = 0; cfg_rows = 0; cfg_stride = 0;
        step(); step();
        reset = 1'b0;
        step();
        chk("reset_addr", address, 16'h0000);
        chk("reset_idle", {valid, busy, done, last_col, last_row}, 5'b0);

        // Single-shot raster with enable held high.
        push_a();
        exp_done++;
        enable = 1'b1;
        do_start(16'h0100, 10'd3, 10'd2, 16'h0040, 1'b0);
        chk("raster_valid_latency", valid, 1'b1);
        wait_idle("raster");
        step();
        chk("raster_sb_empty", sb.size(), 0);
        chk("raster_done", done_seen, exp_done);
        chk("raster_idle_addr", address, 16'h0000);

        // Same window, enable pattern 1,0,0,1.
        push_a();
        exp_done++;
        enable = 1'b0;
        do_start(16'h0100, 10'd3, 10'd2, 16'h0040, 1'b0);
        begin
            int n;
            n = 0;
            while (busy && n < 100) begin
                enable = (n % 4 == 0) || (n % 4 == 3);
                step();
                n++;
            end
            if (n >= 100) chk("gaps_timeout", 32'd1, 32'd0);
        end
        enable = 1'b0;
        step();
        chk("gaps_sb_empty", sb.size(), 0);
        chk("gaps_done", done_seen, exp_done);

        // Continuous wrap through 0xFFFF.
        for (int k = 0; k < 3; k++) begin
            push(16'hFFFE, 0, 0); push(16'hFFFF, 1, 0);
            push(16'h0000, 0, 1); push(16'h0001, 1, 1);
        end
        enable = 1'b1;
        do_start(16'hFFFE, 10'd2, 10'd2, 16'h0002, 1'b1);
        begin
            int vlow;
            vlow = 0;
            for (int k = 0; k < 12; k++) begin
                if (!valid) vlow++;
                step();
            end
            chk("cont_valid_gap", vlow, 0);
        end
        chk("cont_wrapped_addr", address, 16'hFFFE);
        enable = 1'b0; stop = 1'b1;
        step();
        stop = 1'b0;
        chk("cont_stop_idle", {valid, busy}, 2'b00);
        chk("cont_sb_empty", sb.size(), 0);
        chk("cont_no_done", done_seen, exp_done);

        // Start with a zero row count is ignored.
        do_start(16'h0300, 10'd4, 10'd0, 16'h0010, 1'b0);
        chk("zero_rows_idle", {valid, busy}, 2'b00);

        // Start during RUN is ignored.
        push_a();
        exp_done++;
        enable = 1'b0;
        do_start(16'h0100, 10'd3, 10'd2, 16'h0040, 1'b0);
        cfg_base = 16'h0500; cfg_cols = 10'd4; cfg_rows = 10'd4;
        start = 1'b1; enable = 1'b1;
        step();
        start = 1'b0;
        wait_idle("restart");
        enable = 1'b0;
        step();
        chk("restart_sb_empty", sb.size(), 0);
        chk("restart_done", done_seen, exp_done);

        // Stop with enable on the final element: no done.
        push(16'h0200, 0, 1); push(16'h0201, 1, 1);
        enable = 1'b1;
        do_start(16'h0200, 10'd2, 10'd1, 16'h0000, 1'b0);
        step();
        chk("stop_final_addr", {address, last_col, last_row}, {16'h0201, 2'b11});
        stop = 1'b1;
        step();
        stop = 1'b0; enable = 1'b0;
        chk("stop_final_idle", {valid, busy, done}, 3'b000);
        step(); step();
        chk("stop_final_no_done", done_seen, exp_done);
        chk("stop_sb_empty", sb.size(), 0);

        // Degenerate 1x1.
        push(16'h0020, 1, 1);
        exp_done++;
        enable = 1'b0;
        do_start(16'h0020, 10'd1, 10'd1, 16'h0000, 1'b0);
        chk("one_flags", {valid, last_col, last_row, address}, {3'b111, 16'h0020});
        enable = 1'b1;
        step();
        enable = 1'b0;
        chk("one_done_pulse", {done, valid, busy}, 3'b101);
        step();
        chk("one_idle", busy, 1'b0);
        chk("one_done_count", done_seen, exp_done);

        // Reset mid-RUN at address 0x0105.
        for (int k = 0; k < 5; k++) push(16'h0100 + 16'(k), 0, 1);
        enable = 1'b1;
        do_start(16'h0100, 10'd8, 10'd1, 16'h0000, 1'b0);
        repeat (5) step();
        enable = 1'b0;
        chk("pre_reset_addr", address, 16'h0105);
        reset = 1'b1;
        #1;
        chk("async_reset", {address, valid, busy, done, last_col, last_row}, {16'h0000, 5'b0});
        step();
        reset = 1'b0;
        step(); step();
        chk("reset_no_done", done_seen, exp_done);
        chk("reset_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
